// File: rtl/wb_merge.sv
// Writeback merge: arbitrates pipeline commits and buffered long-unit results
// onto the single register-file write port, with x0 suppression, WAW kill of
// stale buffered results, a pending-register mask and a starvation stall.
module wb_merge #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_idx,
  input  logic [31:0] pipe_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_idx,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        write_enable,
  output logic [4:0]  write_idx,
  output logic [31:0] write_data,
  output logic [31:0] pending,
  output logic        pipe_stall_req
);

  localparam int unsigned AgeW = $clog2(STARVE_LIMIT + 1);
  typedef logic [AgeW-1:0] age_t;
  localparam age_t AgeMax = age_t'(STARVE_LIMIT);

  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [4:0]  ent_idx_q [2];
  logic [4:0]  ent_idx_d [2];
  logic [31:0] ent_data_q [2];
  logic [31:0] ent_data_d [2];
  logic [1:0]  ent_live_q, ent_live_d;
  age_t        age_q, age_d;
  logic        we_q, we_d;
  logic [4:0]  widx_q, widx_d;
  logic [31:0] wdata_q, wdata_d;

  logic pipe_wr, head_live, pop, push;

  // Handshake and arbitration decisions from registered state.
  always_comb begin
    pipe_wr   = pipe_valid && (pipe_idx != 5'd0);
    head_live = (count_q != 2'd0) && ent_live_q[head_q];
    // A dead head always drains; a live head drains only when the pipe is silent.
    pop       = (count_q != 2'd0) && (!ent_live_q[head_q] || !pipe_wr);
    lu_ready  = rst_n && (count_q < 2'd2);
    // x0 results are accepted but never buffered.
    push      = lu_valid && lu_ready && (lu_idx != 5'd0);
  end

  // FIFO, age counter and output register next state.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    ent_idx_d  = ent_idx_q;
    ent_data_d = ent_data_q;
    ent_live_d = ent_live_q;

    if (pop) begin
      ent_live_d[head_q] = 1'b0;
      head_d             = ~head_q;
    end

    // Pipeline commits are younger, so they overwrite any buffered result to the same reg.
    for (int e = 0; e < 2; e++) begin
      if (pipe_wr && (ent_idx_q[e] == pipe_idx)) ent_live_d[e] = 1'b0;
    end

    if (push) begin
      ent_idx_d[tail_q]  = lu_idx;
      ent_data_d[tail_q] = lu_data;
      ent_live_d[tail_q] = !(pipe_wr && (pipe_idx == lu_idx));
      tail_d             = ~tail_q;
    end

    count_d = count_q + {1'b0, push} - {1'b0, pop};

    if ((count_q == 2'd0) || pop) begin
      age_d = '0;
    end else if (head_live && (age_q < AgeMax)) begin
      age_d = age_q + age_t'(1);
    end else begin
      age_d = age_q;
    end

    we_d    = 1'b0;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    if (pipe_wr) begin
      we_d    = 1'b1;
      widx_d  = pipe_idx;
      wdata_d = pipe_data;
    end else if (pop && head_live) begin
      we_d    = 1'b1;
      widx_d  = ent_idx_q[head_q];
      wdata_d = ent_data_q[head_q];
    end
  end

  // Pending mask covers only live buffered entries; the RF bypass covers the output reg.
  always_comb begin
    pending = '0;
    for (int e = 0; e < 2; e++) begin
      if (ent_live_q[e]) pending[ent_idx_q[e]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      ent_idx_q  <= '{default: '0};
      ent_data_q <= '{default: '0};
      ent_live_q <= '0;
      age_q      <= '0;
      we_q       <= 1'b0;
      widx_q     <= '0;
      wdata_q    <= '0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      ent_idx_q  <= ent_idx_d;
      ent_data_q <= ent_data_d;
      ent_live_q <= ent_live_d;
      age_q      <= age_d;
      we_q       <= we_d;
      widx_q     <= widx_d;
      wdata_q    <= wdata_d;
    end
  end

  assign write_enable   = we_q;
  assign write_idx      = widx_q;
  assign write_data     = wdata_q;
  assign pipe_stall_req = (age_q >= AgeMax);

endmodule

// File: doc/wb_merge.md
# wb_merge

Writeback merge stage between the in-order pipeline commit point, the long-latency unit (mul/div) and `GPRegisterFile`. It arbitrates both result sources onto the register file's single write port, buffers long-unit results in a 2-entry FIFO, and suppresses writes to x0 so the register file's write-to-read bypass never forwards data for x0. It exports a pending-register mask to the hazard unit and a stall request to prevent starvation of buffered results.

## Interface
- `STARVE_LIMIT`, 8: cycles a valid FIFO head may wait before `pipe_stall_req` asserts (≥1).
- `clk`  in  1  Clock, all state on posedge.
- `rst_n`  in  1  synchronous active-low reset.
- `pipe_valid`  in  1  pipeline commit carries a register write this cycle.
- `pipe_idx`  in  5 (RegId)  destination of pipeline write.
- `pipe_data`  in  32 (Data)  pipeline write value.
- `lu_valid`  in  1  long-unit result offered.
- `lu_idx`  in  5  long-unit destination.
- `lu_data`  in  32  long-unit value.
- `lu_ready`  out  1  long-unit result accepted when `lu_valid && lu_ready` at posedge.
- `write_enable`  out  1  to register file; registered.
- `write_idx`  out  5  to register file; registered.
- `write_data`  out  32  to register file; registered.
- `pending`  out  32  bit i = a live FIFO entry targets xi; bit 0 always 0.
- `pipe_stall_req`  out  1  pipeline must insert a bubble (hold `pipe_valid` low).

## Operation
- FIFO: 2 entries, each {idx, data, live}; count 0..2; circular head/tail pointers.
- Enqueue: `lu_ready = (count < 2)` from registered count only (independent of same-cycle pop). On handshake with `lu_idx != 0`: push {idx, data, live=1}. Handshake with `lu_idx == 0`: accepted, discarded, nothing pushed.
- Output selection each cycle, priority order:
  1. `pipe_valid && pipe_idx != 0`: output register loads pipe write, `write_enable` 1.
  2. else FIFO head live: pop, output loads head, `write_enable` 1.
  3. else `write_enable` 0 (idx/data hold previous values).
- Pipe write with `pipe_idx == 0` is a non-write; FIFO may drain that cycle.
- Killed head (live=0) is popped in any cycle, regardless of pipe activity, without producing a write.
- WAW kill: a pipeline write (idx ≠ 0) clears `live` of every FIFO entry with the same idx, including an entry being pushed that same cycle. Pipeline commits are always younger than buffered long-unit results.
- Simultaneous push and pop at count 1: count stays 1. Push is never possible at count 2.
- `pending` is combinational from the FIFO's live entries only. Entries in the output register are excluded, since the register file bypass covers them.
- Age counter: increments each cycle the head is live and not popped, saturates at `STARVE_LIMIT`, and clears on pop or when the FIFO is empty. `pipe_stall_req = (age >= STARVE_LIMIT)`.
- If `pipe_valid` is asserted while `pipe_stall_req` is high, the pipe still wins. This is a protocol violation; the bench flags it.

## Timing
- Reset (`rst_n` low at posedge): count 0, pointers 0, all live 0, age 0, `write_enable` 0, `write_idx` 0, `write_data` 0. While `rst_n` is low, `lu_ready` is forced 0 and all inputs are ignored.
- Reset mid-operation: buffered results are lost. The long unit is flushed by the same reset.
- Pipe latency: input sampled at edge t, write presented after t, committed by the register file at edge t+1.
- Long-unit latency (no contention): accepted at edge t, output loaded at edge t+1, committed at edge t+2.
- `pending` bit sets after the accept edge and clears after the pop edge or the kill edge.
- Starvation: after a live head waits `STARVE_LIMIT` cycles, `pipe_stall_req` is high from the next cycle until the pop edge.

## Test plan
- Reset: hold `rst_n` low 2 cycles with all inputs active → `write_enable` 0, `lu_ready` 0, `pending` 0. After release, `lu_ready` 1.
- Priority: at edge t, pipe {x3, 0x11} and lu {x5, 0x22} → cycle t+1 write x3=0x11; cycle t+2 write x5=0x22; `pending[5]` 1 only during cycle t+1.
- Full FIFO: 3 back-to-back lu offers {x1, x2, x4} while pipe writes x7 every cycle → third offer sees `lu_ready` 0. After `STARVE_LIMIT`=8 waiting cycles `pipe_stall_req` = 1. When the pipe idles, x1, x2, x4 drain in order.
- WAW kill: lu {x9, 0xAA} buffered, then pipe {x9, 0xBB} → only x9=0xBB is written, `pending[9]` clears, and the killed head pops with no write.
- x0: pipe {x0, 0xFF} and lu {x0, 0xEE} → no `write_enable`, lu handshake completes, FIFO count unchanged.
- Mid-reset: 2 entries buffered, `rst_n` low for 1 cycle → FIFO empty, no writes issued afterwards, `pending` 0.
